// File: rtl/sd_access_arb.sv
// sd_access_arb: two-requester, one-sector-at-a-time access arbiter in front of
// an SD card controller. Grants round-robin, issues one start pulse per grant,
// waits for the controller's busy to rise and fall, then reports done or err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   sd_init_done               card initialised; gates grants, aborts on loss
//   reqN_valid/we/addr         requester N one-sector request
//   reqN_ack/done/err          one-cycle status pulses back to requester N
//   reqN_wr_data               requester N write data
//   reqN_wr_req/rd_val_en      controller data strobes, routed to the owner only
//   wr_start_en, rd_start_en   start pulses to the controller
//   wr_sec_addr, rd_sec_addr   sector address to the controller (held between accesses)
//   wr_busy, rd_busy           controller busy flags
//   wr_req, wr_data            controller write-data request / owner's write data
//   rd_val_en                  controller read-data valid strobe
module sd_access_arb #(
   parameter logic [15:0] BUSY_TIMEOUT = 16'd4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sd_init_done,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [15:0] req0_wr_data,
   output logic        req0_ack,
   output logic        req0_done,
   output logic        req0_err,
   output logic        req0_wr_req,
   output logic        req0_rd_val_en,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [15:0] req1_wr_data,
   output logic        req1_ack,
   output logic        req1_done,
   output logic        req1_err,
   output logic        req1_wr_req,
   output logic        req1_rd_val_en,
   output logic        wr_start_en,
   output logic        rd_start_en,
   output logic [31:0] wr_sec_addr,
   output logic [31:0] rd_sec_addr,
   input  logic        wr_busy,
   input  logic        rd_busy,
   input  logic        wr_req,
   output logic [15:0] wr_data,
   input  logic        rd_val_en
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic        owner, owner_nxt;
   logic        we_q, we_nxt;
   logic [31:0] addr_q, addr_nxt;
   logic        last_q, last_nxt;
   logic [15:0] cnt_q, cnt_nxt;
   logic [1:0]  ack_nxt, done_nxt, err_nxt;
   logic        wr_start_nxt, rd_start_nxt;
   logic [31:0] wr_sec_nxt, rd_sec_nxt;
   logic        grant_c;
   logic        sel_busy_c;
   logic        active_c;
   logic [1:0]  owner_mask_c;

   assign sel_busy_c   = we_q ? wr_busy : rd_busy;
   assign owner_mask_c = owner ? 2'b10 : 2'b01;
   assign active_c     = (state == S_ISSUE) || (state == S_WAIT_HI) || (state == S_WAIT_LO);

   // Data-path forwarding to/from the current owner only.
   assign wr_data        = active_c ? (owner ? req1_wr_data : req0_wr_data) : 16'd0;
   assign req0_wr_req    = active_c && !owner && wr_req;
   assign req1_wr_req    = active_c &&  owner && wr_req;
   assign req0_rd_val_en = active_c && !owner && rd_val_en;
   assign req1_rd_val_en = active_c &&  owner && rd_val_en;

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      we_nxt       = we_q;
      addr_nxt     = addr_q;
      last_nxt     = last_q;
      cnt_nxt      = cnt_q;
      ack_nxt      = 2'b00;
      done_nxt     = 2'b00;
      err_nxt      = 2'b00;
      wr_start_nxt = 1'b0;
      rd_start_nxt = 1'b0;
      wr_sec_nxt   = wr_sec_addr;
      rd_sec_nxt   = rd_sec_addr;
      grant_c      = 1'b0;

      case (state)
         S_IDLE: begin
            if (sd_init_done && (req0_valid || req1_valid)) begin
               // Both asking: the one not served last wins.
               grant_c   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
               owner_nxt = grant_c;
               we_nxt    = grant_c ? req1_we   : req0_we;
               addr_nxt  = grant_c ? req1_addr : req0_addr;
               ack_nxt   = grant_c ? 2'b10 : 2'b01;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!sd_init_done) begin
               err_nxt   = owner_mask_c;
               state_nxt = S_IDLE;
            end else begin
               wr_start_nxt = we_q;
               rd_start_nxt = ~we_q;
               if (we_q) wr_sec_nxt = addr_q;
               else      rd_sec_nxt = addr_q;
               cnt_nxt   = 16'd0;
               state_nxt = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (!sd_init_done || (!sel_busy_c && cnt_q == BUSY_TIMEOUT)) begin
               err_nxt   = owner_mask_c;
               state_nxt = S_IDLE;
            end else if (sel_busy_c) begin
               state_nxt = S_WAIT_LO;
            end else begin
               cnt_nxt = cnt_q + 16'd1;
            end
         end
         S_WAIT_LO: begin
            if (!sd_init_done) begin
               err_nxt   = owner_mask_c;
               state_nxt = S_IDLE;
            end else if (!sel_busy_c) begin
               done_nxt  = owner_mask_c;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            last_nxt  = owner;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         owner       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         last_q      <= 1'b1;
         cnt_q       <= 16'd0;
         req0_ack    <= 1'b0;
         req1_ack    <= 1'b0;
         req0_done   <= 1'b0;
         req1_done   <= 1'b0;
         req0_err    <= 1'b0;
         req1_err    <= 1'b0;
         wr_start_en <= 1'b0;
         rd_start_en <= 1'b0;
         wr_sec_addr <= 32'd0;
         rd_sec_addr <= 32'd0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         we_q        <= we_nxt;
         addr_q      <= addr_nxt;
         last_q      <= last_nxt;
         cnt_q       <= cnt_nxt;
         req0_ack    <= ack_nxt[0];
         req1_ack    <= ack_nxt[1];
         req0_done   <= done_nxt[0];
         req1_done   <= done_nxt[1];
         req0_err    <= err_nxt[0];
         req1_err    <= err_nxt[1];
         wr_start_en <= wr_start_nxt;
         rd_start_en <= rd_start_nxt;
         wr_sec_addr <= wr_sec_nxt;
         rd_sec_addr <= rd_sec_nxt;
      end
   end

endmodule

// File: doc/sd_access_arb.md
SD_ACCESS_ARB -- requirements
Module: sd_access_arb

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 16'd4096: max cycles from the start pulse to busy rising.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sd_init_done  input  1  high while the SD card is initialised.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester N asks for a one-sector access.
REQ-006 SHALL have ports req0_we / req1_we  input  1  1 = write sector, 0 = read sector.
REQ-007 SHALL have ports req0_addr / req1_addr  input  32  sector address.
REQ-008 SHALL have ports req0_ack / req1_ack  output  1  one-cycle pulse: request accepted, inputs latched.
REQ-009 SHALL have ports req0_done / req1_done  output  1  one-cycle pulse: access finished.
REQ-010 SHALL have ports req0_err / req1_err  output  1  one-cycle pulse: access aborted (timeout or init lost).
REQ-011 SHALL have ports req0_wr_data / req1_wr_data  input  16  write data from requester N.
REQ-012 SHALL have ports req0_wr_req / req1_wr_req  output  1  wr_req forwarded to the owner only.
REQ-013 SHALL have ports req0_rd_val_en / req1_rd_val_en  output  1  rd_val_en forwarded to the owner only.
REQ-014 SHALL have ports wr_start_en, rd_start_en  output  1  start pulses to the SD controller.
REQ-015 SHALL have ports wr_sec_addr, rd_sec_addr  output  32  sector address to the SD controller.
REQ-016 SHALL have ports wr_busy, rd_busy  input  1  SD controller busy flags.
REQ-017 SHALL have ports wr_req  input  1, and wr_data  output  16: data request from, and data to, the SD controller.
REQ-018 SHALL have port rd_val_en  input  1; rd_val_data is wired directly to both requesters and does not pass through this block.

Function
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> DONE -> IDLE.
REQ-020 In IDLE with sd_init_done=1, SHALL grant one valid requester, latch its we/addr and owner id, pulse its ack, and go to ISSUE next cycle.
REQ-021 SHALL arbitrate round-robin: with both valid, grant the requester other than the last one served; after reset, requester 0 has priority.
REQ-022 In ISSUE, SHALL pulse exactly one of wr_start_en/rd_start_en for one cycle, per the latched we, with the matching sec_addr, then go to WAIT_HI.
REQ-023 In WAIT_HI, SHALL wait for the selected busy to read 1, then go to WAIT_LO; a 16-bit counter SHALL count WAIT_HI cycles.
REQ-024 If the counter reaches BUSY_TIMEOUT in WAIT_HI, SHALL pulse the owner's err and return to IDLE.
REQ-025 In WAIT_LO, SHALL go to DONE on the first cycle the selected busy reads 0; there is no timeout in WAIT_LO.
REQ-026 In DONE, SHALL pulse the owner's done for one cycle, update the last-served pointer, and return to IDLE.
REQ-027 Ack-to-start latency SHALL be 1 cycle; busy-low to done latency SHALL be 1 cycle.
REQ-028 wr_data SHALL be the owner's wr_data, combinationally; wr_req and rd_val_en SHALL be combinationally routed to the owner only; non-owners SHALL see 0.
REQ-029 Outside ISSUE/WAIT_HI/WAIT_LO, forwarded strobes SHALL be 0 and wr_data SHALL be 16'd0.
REQ-030 If sd_init_done falls in ISSUE/WAIT_HI/WAIT_LO, SHALL pulse the owner's err and go to IDLE next cycle.
REQ-031 No grant SHALL occur while sd_init_done=0; valid requests stay pending.
REQ-032 A requester's valid seen in the same cycle as its own done SHALL NOT be granted before IDLE is re-entered.
REQ-033 sec_addr outputs SHALL hold their last value between accesses.

Reset
REQ-034 On rst_n=0, SHALL asynchronously force: state IDLE; all start/ack/done/err pulses 0; sec_addrs 32'd0; counter 0; last-served pointer = requester 1 (so 0 wins first).
REQ-035 Reset mid-access SHALL abandon the access without any done/err pulse.

Verification
REQ-036 req0 write 20000, busy high 3 cycles after start for 600 cycles -> ack0, then wr_start_en with wr_sec_addr=20000, done0 1 cycle after busy falls.
REQ-037 req0 and req1 held valid continuously -> grant order 0,1,0,1; exactly one start pulse per grant.
REQ-038 Read by req1, busy never rises, BUSY_TIMEOUT=16 -> err1 pulses 17 cycles after rd_start_en; FSM back in IDLE.
REQ-039 sd_init_done dropped during WAIT_LO -> err to owner next cycle; new requests held until sd_init_done=1.
REQ-040 req1 write with wr_req strobed 256 times -> req1_wr_req=256 pulses, req0_wr_req=0; wr_data equals req1_wr_data.
REQ-041 rst_n asserted during WAIT_LO -> all outputs at reset values immediately; no done pulse after release.
